regfile_dump_reader: RTL and testbench



---
 rtl/regfile_dump_reader.sv | 113 +++++++++++
 tb/tb_regfile_dump_reader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Sweeps registers FIRST_REG..LAST_REG through one read port and streams each word out on valid/ready.
// Optional DUMP_CSUM_EN appends a beat carrying the XOR of every dumped word.
module regfile_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_REG);

`ifdef DUMP_CSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, CSUM, FIN} state_t;
    logic [DATA_W-1:0] csum;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SEND, FIN} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // idx is parked at FIRST_REG whenever idle, so the read port needs no mux.
    assign rd_addr = idx;
    assign busy    = (state != IDLE);
    assign done    = (state == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= FIRST;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
`ifdef DUMP_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= FIRST;
                        state <= LOAD;
`ifdef DUMP_CSUM_EN
                        csum  <= '0;
`endif
                    end
                end
                LOAD: begin
                    out_data  <= rd_data;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
`ifdef DUMP_CSUM_EN
                    // The checksum beat is the last one, so data beats never carry out_last.
                    out_last  <= 1'b0;
                    csum      <= csum ^ rd_data;
`else
                    out_last  <= (idx == LAST);
`endif
                    state     <= SEND;
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        if (idx == LAST) begin
`ifdef DUMP_CSUM_EN
                            out_valid <= 1'b1;
                            out_data  <= csum;
                            out_idx   <= LAST;
                            out_last  <= 1'b1;
                            state     <= CSUM;
`else
                            out_valid <= 1'b0;
                            state     <= FIN;
`endif
                        end else begin
                            out_valid <= 1'b0;
                            idx       <= idx + 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
`ifdef DUMP_CSUM_EN
                CSUM: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= FIN;
                    end
                end
`endif
                FIN: begin
                    idx   <= FIRST;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: table-driven dumps, hand-written corner sequences and random backpressure runs.
module tb_regfile_dump_reader;

`ifdef DUMP_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // main instance: full 0..31 sweep
    logic        start, busy, done, out_valid, out_ready, out_last;
    logic [4:0]  rd_addr, out_idx;
    logic [31:0] rd_data, out_data;
    logic [31:0] rf [32];

    // second instance: single register 5
    logic        b_start, b_busy, b_done, b_valid, b_ready, b_last;
    logic [4:0]  b_rd_addr, b_idx;
    logic [31:0] b_rd_data, b_data;
    logic [31:0] rf_b [32];

    always_comb rd_data   = (rd_addr == 5'd0) ? 32'd0 : rf[rd_addr];
    always_comb b_rd_data = (b_rd_addr == 5'd0) ? 32'd0 : rf_b[b_rd_addr];

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .out_last(out_last));

    regfile_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(5), .LAST_REG(5)) u_one (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .out_valid(b_valid), .out_ready(b_ready),
        .out_idx(b_idx), .out_data(b_data), .out_last(b_last));

    typedef struct packed {
        logic [4:0]  idx;
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] x1;
        logic [31:0] x2;
        logic [31:0] exp_xor;
    } vec_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int    n_chk = 0;
    int    n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected stream straight from the rules: every register in order, x0 reads 0,
    // plus a trailing XOR beat when the checksum feature is built in.
    task automatic build_model();
        logic [31:0] x, v;
        exp_q.delete();
        x = '0;
        for (int i = 0; i < 32; i++) begin
            v = (i == 0) ? 32'd0 : rf[i];
            x ^= v;
            exp_q.push_back('{idx: 5'(i), last: (!CSUM && i == 31), data: v});
        end
        if (CSUM) exp_q.push_back('{idx: 5'd31, last: 1'b1, data: x});
    endtask

    task automatic compare_beats(input string nm);
        int n;
        check({nm, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({nm, "_beat"}, 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    // Runs one dump. Beats are recorded at the sample point where valid&&ready is
    // presented, i.e. the beat accepted at the following edge.
    task automatic run_dump(input int pct, input int stall_idx, input int stall_len,
                            input int restart_idx, input int write_idx,
                            input logic [31:0] wv0, input logic [31:0] wv1,
                            output int first_cyc, output int done_cyc, output int n_done);
        bit    prev_hold = 0, stalled = 0, restarted = 0, wrote = 0;
        int    stall_left = 0;
        beat_t prev, cur;
        prev = '0;
        got_q.delete();
        first_cyc = -1; done_cyc = -1; n_done = 0;
        @(posedge clk); #1;
        start = 1'b1;
        out_ready = ($urandom_range(99) < pct);
        for (int cyc = 1; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            cur = '{idx: out_idx, last: out_last, data: out_data};
            if (prev_hold) check("hold_stable", {25'd0, out_valid, cur}, {25'd0, 1'b1, prev});
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (restart_idx >= 0 && !restarted && out_valid && out_idx == 5'(restart_idx)) begin
                start = 1'b1;
                restarted = 1;
            end
            if (write_idx >= 0 && !wrote && out_valid && out_idx == 5'(write_idx)) begin
                rf[write_idx] = wv0;
                rf[write_idx + 2] = wv1;
                wrote = 1;
            end
            if (stall_idx >= 0 && !stalled && out_valid && out_idx == 5'(stall_idx)) begin
                stall_left = stall_len;
                stalled = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ($urandom_range(99) < pct);
            end
            if (out_valid && out_ready) got_q.push_back(cur);
            prev_hold = out_valid && !out_ready;
            prev = cur;
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
        end
        out_ready = 1'b0;
        if (done_cyc < 0) check("dump_timeout", 64'd0, 64'd1);
    endtask

    vec_t vecs[4];
    int   fc, dc, nd;
    logic [31:0] x;

    initial begin
        vecs[0] = '{x1: 32'h12345678, x2: 32'h87654321, exp_xor: 32'h95511559};
        vecs[1] = '{x1: 32'hFFFFFFFF, x2: 32'h00000000, exp_xor: 32'hFFFFFFFF};
        vecs[2] = '{x1: 32'hA5A5A5A5, x2: 32'h5A5A5A5A, exp_xor: 32'hFFFFFFFF};
        vecs[3] = '{x1: 32'hDEADBEEF, x2: 32'hDEADBEEF, exp_xor: 32'h00000000};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; b_start = 1'b0; b_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin rf[i] = '0; rf_b[i] = $urandom; end
        rf_b[5] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    64'(busy),      64'd0);
        check("rst_done",    64'(done),      64'd0);
        check("rst_valid",   64'(out_valid), 64'd0);
        check("rst_last",    64'(out_last),  64'd0);
        check("rst_idx",     64'(out_idx),   64'd0);
        check("rst_data",    64'(out_data),  64'd0);
        check("rst_rd_addr", 64'(rd_addr),   64'd0);
        check("rst_b_addr",  64'(b_rd_addr), 64'd5);
        rst = 1'b0;

        // table: x1/x2 preload, full-speed dump, stream XOR against a hand-computed constant
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 32; i++) rf[i] = '0;
            rf[1] = vecs[t].x1;
            rf[2] = vecs[t].x2;
            build_model();
            run_dump(100, -1, 0, -1, -1, '0, '0, fc, dc, nd);
            compare_beats("table");
            check("first_valid_cyc", 64'(fc), 64'd2);
            check("done_cyc", 64'(dc), CSUM ? 64'd66 : 64'd65);
            check("done_count", 64'(nd), 64'd1);
            if (CSUM) begin
                check("csum_beat", (got_q.size() > 0) ? 64'(got_q[$].data) : 64'hX, 64'(vecs[t].exp_xor));
            end else begin
                x = '0;
                foreach (got_q[i]) x ^= got_q[i].data;
                check("stream_xor", 64'(x), 64'(vecs[t].exp_xor));
            end
        end

        // backpressure: 5 stalled cycles on idx 3
        build_model();
        run_dump(100, 3, 5, -1, -1, '0, '0, fc, dc, nd);
        compare_beats("stall");
        check("stall_done_cyc", 64'(dc), CSUM ? 64'd71 : 64'd70);

        // start while busy at idx 10 is ignored
        run_dump(100, -1, 0, 10, -1, '0, '0, fc, dc, nd);
        compare_beats("restart");
        check("restart_done_count", 64'(nd), 64'd1);

        // snapshot: writes during SEND of idx 4 hit idx 4 (already captured) and idx 6 (not yet)
        for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h01010101;
        run_dump(100, -1, 0, -1, 4, 32'hCAFE0004, 32'hCAFE0006, fc, dc, nd);
        build_model();
        exp_q[4].data = 32'h04040404;
        if (CSUM) exp_q[32].data = exp_q[32].data ^ 32'hCAFE0004 ^ 32'h04040404;
        compare_beats("snapshot");

        // reset during SEND of idx 7
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        fc = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (out_valid && out_idx == 5'd7) begin fc = 1; break; end
        end
        check("reach_idx7", 64'(fc), 64'd1);
        out_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_valid",   64'(out_valid), 64'd0);
        check("mid_rst_busy",    64'(busy),      64'd0);
        check("mid_rst_rd_addr", 64'(rd_addr),   64'd0);
        check("mid_rst_idx",     64'(out_idx),   64'd0);
        check("mid_rst_data",    64'(out_data),  64'd0);
        check("mid_rst_last",    64'(out_last),  64'd0);
        nd = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        out_ready = 1'b0;
        check("no_done_after_rst", 64'(nd), 64'd0);
        build_model();
        run_dump(100, -1, 0, -1, -1, '0, '0, fc, dc, nd);
        compare_beats("after_rst");

        // single-register instance
        @(posedge clk); #1;
        b_start = 1'b1; b_ready = 1'b1;
        got_q.delete();
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            b_start = 1'b0;
            if (b_done) nd++;
            if (b_valid) got_q.push_back('{idx: b_idx, last: b_last, data: b_data});
        end
        b_ready = 1'b0;
        exp_q.delete();
        if (CSUM) exp_q.push_back('{idx: 5'd5, last: 1'b0, data: 32'hDEADBEEF});
        exp_q.push_back('{idx: 5'd5, last: 1'b1, data: 32'hDEADBEEF});
        compare_beats("single");
        check("single_done_count", 64'(nd), 64'd1);

        // random contents (x0 included) with random backpressure
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            build_model();
            run_dump(int'($urandom_range(90, 25)), -1, 0, -1, -1, '0, '0, fc, dc, nd);
            compare_beats("random");
            check("random_done_count", 64'(nd), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
